// File: rtl/halfband_seq_ctrl.sv
// Sequencer for a shared-MAC halfband decimator: owns the sample RAM write pointer,
// counts decimation strobes and issues 8 symmetric pair ops plus one centre op per output.
module halfband_seq_ctrl #(
  parameter int DECIM   = 1,
  parameter int RATE    = 2,
  parameter int MAC_LAT = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       strobe_in,
  input  logic       clear_overrun,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [4:0] rd_addr_a,
  output logic [4:0] rd_addr_b,
  output logic [3:0] coeff_idx,
  output logic       pair_en,
  output logic       mac_valid,
  output logic       mac_clear,
  output logic       mac_last,
  output logic       strobe_out,
  output logic       busy,
  output logic       overrun,
  output logic [1:0] state_dbg
);

  // Handshake: strobe_in is a single-cycle qualifier (no backpressure); each MAC op is
  // valid for exactly the cycle mac_valid is high, and strobe_out marks the one cycle
  // the accumulator result may be taken.
  typedef enum logic [1:0] {IDLE, PAIR, CENTER, DRAIN} state_t;

  localparam logic [7:0] RATE_M1 = 8'(RATE - 1);
  localparam logic [2:0] LAT_M1  = 3'(MAC_LAT - 1);

  state_t     state;
  logic [4:0] wptr;
  logic [4:0] base;
  logic [4:0] base_next;
  logic [7:0] count;
  logic       pending;
  logic [2:0] j;
  logic [2:0] dcnt;

  logic       trigger;
  logic       drain_last;
  logic       launch;
  logic [4:0] launch_base;
  logic [2:0] jn;
  logic [4:0] jn2;

  assign wr_en     = enable & strobe_in;
  assign wr_addr   = wptr;
  assign state_dbg = state;

  assign trigger     = wr_en && ((DECIM == 0) || (count == RATE_M1));
  assign drain_last  = (state == DRAIN) && (dcnt == LAT_M1);
  // A trigger landing on the final drain cycle starts directly, skipping the IDLE hop.
  assign launch      = ((state == IDLE) && pending) || (drain_last && (pending || trigger));
  assign launch_base = pending ? base_next : wptr;
  assign jn          = j + 3'd1;
  assign jn2         = {1'b0, jn, 1'b0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wptr       <= '0;
      base       <= '0;
      base_next  <= '0;
      count      <= '0;
      pending    <= 1'b0;
      j          <= '0;
      dcnt       <= '0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      coeff_idx  <= '0;
      pair_en    <= 1'b0;
      mac_valid  <= 1'b0;
      mac_clear  <= 1'b0;
      mac_last   <= 1'b0;
      strobe_out <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 5'd1;
      if (!enable) begin
        state      <= IDLE;
        pending    <= 1'b0;
        count      <= '0;
        pair_en    <= 1'b0;
        mac_valid  <= 1'b0;
        mac_clear  <= 1'b0;
        mac_last   <= 1'b0;
        strobe_out <= 1'b0;
        busy       <= 1'b0;
      end else begin
        if (strobe_in) count <= trigger ? 8'd0 : count + 8'd1;
        pair_en    <= 1'b0;
        mac_valid  <= 1'b0;
        mac_clear  <= 1'b0;
        mac_last   <= 1'b0;
        strobe_out <= 1'b0;

        // A fresh overrun is written after the clear so that set wins.
        if (clear_overrun) overrun <= 1'b0;
        if (launch) begin
          pending <= pending && trigger;
          if (pending && trigger) base_next <= wptr;
        end else if (trigger) begin
          if (pending) begin
            overrun <= 1'b1;
          end else begin
            pending   <= 1'b1;
            base_next <= wptr;
          end
        end

        if (launch) begin
          state     <= PAIR;
          j         <= '0;
          base      <= launch_base;
          rd_addr_a <= launch_base;
          rd_addr_b <= launch_base + 5'd2;
          coeff_idx <= 4'd0;
          pair_en   <= 1'b1;
          mac_valid <= 1'b1;
          mac_clear <= 1'b1;
          busy      <= 1'b1;
        end else begin
          case (state)
            PAIR: begin
              mac_valid <= 1'b1;
              if (j == 3'd7) begin
                state     <= CENTER;
                rd_addr_a <= base - 5'd15;
                coeff_idx <= 4'd8;
                mac_last  <= 1'b1;
              end else begin
                j         <= jn;
                rd_addr_a <= base - jn2;
                rd_addr_b <= base + 5'd2 + jn2;
                coeff_idx <= {1'b0, jn};
                pair_en   <= 1'b1;
              end
            end
            CENTER: begin
              state      <= DRAIN;
              dcnt       <= '0;
              strobe_out <= (MAC_LAT == 1);
            end
            DRAIN: begin
              if (drain_last) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                dcnt       <= dcnt + 3'd1;
                strobe_out <= ((dcnt + 3'd1) == LAT_M1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
